// File: rtl/alu_issue_stage.sv
// ALU issue stage: a 2-entry request FIFO in front of the ALU. Illegal opcodes are
// accepted and dropped. A saturating counter and a sticky error flag record each drop.
module alu_issue_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] operand_a,
    output logic [DATA_W-1:0] operand_b,
    output logic [3:0]        alu_control,
    output logic [CNT_W-1:0]  illegal_cnt,
    output logic              err_sticky,
    input  logic              err_clr
);

    typedef struct packed {
        logic [3:0]        op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } entry_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    entry_t     mem [2];
    entry_t     head;
    logic [1:0] count;
    logic       wr_ptr;
    logic       rd_ptr;
    logic       op_legal;
    logic       accept;
    logic       push;
    logic       pop;
    logic       illegal_acc;

    // The ready signal is decoded from the registered occupancy only. Because of this,
    // out_ready never reaches in_ready in the same cycle.
    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);

    always_comb begin
        op_legal = 1'b0;
        case (in_op)
            4'b0000, 4'b0001, 4'b0010,
            4'b0100, 4'b0101, 4'b0110, 4'b0111: op_legal = 1'b1;
            default:                            op_legal = 1'b0;
        endcase
    end

    // The handshake is masked while rst is high. A request seen during reset is never taken.
    assign accept      = in_valid && in_ready && !rst;
    assign push        = accept && op_legal;
    assign illegal_acc = accept && !op_legal;
    assign pop         = out_valid && out_ready && !rst;

    // NOTE: registered state uses non-blocking assignments. Every flop then samples
    // the values from before the edge, whatever order the blocks run in.
    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset. A slot is only read when count says it is
    // valid, and the outputs are forced to zero when the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{op: in_op, a: in_a, b: in_b};
    end

    assign head        = mem[rd_ptr];
    assign operand_a   = out_valid ? head.a  : '0;
    assign operand_b   = out_valid ? head.b  : '0;
    assign alu_control = out_valid ? head.op : 4'b0000;

    // When an illegal accept and err_clr arrive together, the accept wins.
    // The count restarts at one instead of going to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_cnt <= '0;
            err_sticky  <= 1'b0;
        end else if (illegal_acc) begin
            err_sticky <= 1'b1;
            if (err_clr)
                illegal_cnt <= CNT_W'(1);
            else if (illegal_cnt != CNT_MAX)
                illegal_cnt <= illegal_cnt + CNT_W'(1);
        end else if (err_clr) begin
            illegal_cnt <= '0;
            err_sticky  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage.
// Inputs change 1 time unit after the rising edge. Outputs are checked at that same point.
module tb_alu_issue_stage;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] operand_a;
    logic [DATA_W-1:0] operand_b;
    logic [3:0]        alu_control;
    logic [CNT_W-1:0]  illegal_cnt;
    logic              err_sticky;
    logic              err_clr;

    int checks = 0;
    int errors = 0;

    alu_issue_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .operand_a(operand_a), .operand_b(operand_b), .alu_control(alu_control),
        .illegal_cnt(illegal_cnt), .err_sticky(err_sticky), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input int a, input int b);
        in_valid = v;
        in_op    = op;
        in_a     = DATA_W'(a);
        in_b     = DATA_W'(b);
    endtask

    task automatic expect_head(input string name, input logic [3:0] op, input int a, input int b);
        checks++;
        if (out_valid !== 1'b1 || alu_control !== op || operand_a !== DATA_W'(a) || operand_b !== DATA_W'(b)) begin
            errors++;
            $display("FAIL %s: got valid=%b op=%h a=%0d b=%0d, want valid=1 op=%h a=%0d b=%0d",
                     name, out_valid, alu_control, operand_a, operand_b, op, a, b);
        end
    endtask

    task automatic expect_empty(input string name);
        checks++;
        if (out_valid !== 1'b0 || alu_control !== 4'h0 || operand_a !== '0 || operand_b !== '0) begin
            errors++;
            $display("FAIL %s: got valid=%b op=%h a=%0d b=%0d, want all zero",
                     name, out_valid, alu_control, operand_a, operand_b);
        end
    endtask

    task automatic expect_ready(input string name, input logic exp);
        checks++;
        if (in_ready !== exp) begin
            errors++;
            $display("FAIL %s: in_ready=%b, want %b", name, in_ready, exp);
        end
    endtask

    task automatic expect_err(input string name, input int cnt, input logic sticky);
        checks++;
        if (illegal_cnt !== CNT_W'(cnt) || err_sticky !== sticky) begin
            errors++;
            $display("FAIL %s: illegal_cnt=%0d err_sticky=%b, want %0d %b",
                     name, illegal_cnt, err_sticky, cnt, sticky);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; err_clr = 1'b0; out_ready = 1'b0;
        drive(1'b0, 4'h0, 0, 0);
        step(); step();
        rst = 1'b0;
        expect_empty("reset_outputs");
        expect_ready("reset_in_ready", 1'b1);
        expect_err("reset_err", 0, 1'b0);
    endtask

    task automatic test_single_push();
        out_ready = 1'b1;
        drive(1'b1, 4'b0000, 5, 7);
        step();
        drive(1'b0, 4'h0, 0, 0);
        expect_head("single_issue", 4'b0000, 5, 7);
        step();
        expect_empty("single_drained");
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 4'b0001, 1, 11);
        step();
        expect_ready("bp_after_first", 1'b1);
        drive(1'b1, 4'b0010, 2, 22);
        step();
        expect_ready("bp_full", 1'b0);
        drive(1'b1, 4'b0100, 3, 33);
        step();
        expect_ready("bp_third_held", 1'b0);
        expect_head("bp_head_stable", 4'b0001, 1, 11);
        out_ready = 1'b1;
        step();
        expect_ready("bp_ready_rises", 1'b1);
        expect_head("bp_drain_2", 4'b0010, 2, 22);
        step();
        drive(1'b0, 4'h0, 0, 0);
        expect_head("bp_drain_3", 4'b0100, 3, 33);
        step();
        expect_empty("bp_drained");
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        drive(1'b1, 4'b0011, 9, 9);
        step();
        expect_empty("illegal_0011_dropped");
        drive(1'b1, 4'b1111, 9, 9);
        step();
        drive(1'b0, 4'h0, 0, 0);
        expect_empty("illegal_1111_dropped");
        expect_err("illegal_count_two", 2, 1'b1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        expect_err("illegal_cleared", 0, 1'b0);
    endtask

    task automatic test_saturation();
        drive(1'b1, 4'b1000, 0, 0);
        for (int i = 0; i < 300; i++) step();
        expect_err("saturate_255", 255, 1'b1);
        drive(1'b1, 4'b1001, 0, 0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        drive(1'b0, 4'h0, 0, 0);
        expect_err("clr_collision", 1, 1'b1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        expect_err("clr_after_collision", 0, 1'b0);
    endtask

    task automatic test_err_clr_fifo();
        out_ready = 1'b0;
        drive(1'b1, 4'b0101, 44, 55);
        step();
        drive(1'b0, 4'h0, 0, 0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        expect_head("clr_keeps_fifo", 4'b0101, 44, 55);
        out_ready = 1'b1;
        step();
        expect_empty("clr_fifo_drained");
    endtask

    task automatic test_back_to_back();
        logic [3:0] ops [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101, 4'b0110};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, ops[i], 100 + i, 200 + i);
            step();
            expect_head($sformatf("stream_%0d", i), ops[i], 100 + i, 200 + i);
            expect_ready($sformatf("stream_ready_%0d", i), 1'b1);
        end
        drive(1'b0, 4'h0, 0, 0);
        step();
        expect_empty("stream_drained");
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive(1'b1, 4'b0110, 170, 1);
        step();
        drive(1'b1, 4'b0111, 187, 2);
        step();
        expect_ready("mid_full", 1'b0);
        rst = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 4'b0001, 204, 3);
        step();
        drive(1'b1, 4'b1100, 0, 0);
        step();
        rst = 1'b0;
        drive(1'b0, 4'h0, 0, 0);
        expect_empty("mid_reset_empty");
        expect_ready("mid_reset_ready", 1'b1);
        expect_err("mid_reset_no_illegal", 0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            expect_empty($sformatf("mid_no_stale_%0d", i));
        end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_backpressure();
        test_illegal();
        test_saturation();
        test_err_clr_fifo();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand width; must match the ALU operand width.
REQ-002 SHALL have parameter CNT_W, default 8, width of the illegal-opcode counter.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  upstream request valid.
REQ-006 SHALL have port in_ready  output  1  stage can accept a request this cycle.
REQ-007 SHALL have port in_op  input  4  requested ALU control code.
REQ-008 SHALL have ports in_a and in_b  input  DATA_W  requested operands.
REQ-009 SHALL have port out_valid  output  1  head entry presented to the ALU is valid.
REQ-010 SHALL have port out_ready  input  1  downstream (ALU/writeback) consumes the head this cycle.
REQ-011 SHALL have ports operand_a and operand_b  output  DATA_W, and port alu_control  output  4, which drive the ALU inputs directly.
REQ-012 SHALL have port illegal_cnt  output  CNT_W  count of dropped illegal requests.
REQ-013 SHALL have port err_sticky  output  1  set on any illegal request.
REQ-014 SHALL have port err_clr  input  1  clears err_sticky and illegal_cnt.

Function
REQ-015 SHALL buffer requests in a 2-entry FIFO with occupancy count 0..2.
REQ-016 SHALL drive in_ready = (count < 2), registered-only; in_ready SHALL have no combinational path from out_ready.
REQ-017 SHALL treat a request as accepted when in_valid && in_ready.
REQ-018 SHALL classify opcodes 0000, 0001, 0010, 0100, 0101, 0110 and 0111 as legal; all others (0011, 1xxx) SHALL be illegal.
REQ-019 SHALL push an accepted legal request into the FIFO.
REQ-020 SHALL complete the handshake for an accepted illegal request, but SHALL NOT push it; it SHALL increment illegal_cnt and set err_sticky.
REQ-021 SHALL saturate illegal_cnt at all-ones.
REQ-022 SHALL drive out_valid = (count > 0); operand_a, operand_b and alu_control SHALL come from the head entry, and SHALL be all-zero when count == 0.
REQ-023 SHALL pop the head when out_valid && out_ready.
REQ-024 SHALL hold head contents stable while out_valid && !out_ready.
REQ-025 Latency: a legal push into an empty FIFO SHALL appear on out_valid/operands on the next cycle; there SHALL be no same-cycle bypass.
REQ-026 When count == 1 and a push and a pop occur in the same cycle, count SHALL remain 1 and the new entry SHALL become the head.
REQ-027 When count == 2 and a pop occurs, count SHALL become 1 and in_ready SHALL rise on the next cycle.
REQ-028 SHALL preserve FIFO order; write and read pointers SHALL wrap modulo 2.
REQ-029 err_clr SHALL zero illegal_cnt and clear err_sticky next cycle.
REQ-030 An illegal accept in the same cycle as err_clr SHALL win: illegal_cnt becomes 1 and err_sticky becomes 1.
REQ-031 err_clr SHALL NOT affect FIFO contents.

Reset
REQ-032 On rst, count, the pointers, illegal_cnt and err_sticky SHALL be 0, out_valid SHALL be 0, operands and alu_control SHALL be 0, and in_ready SHALL be 1 on the cycle after rst deasserts.
REQ-033 rst mid-operation SHALL discard all buffered entries; no pending entry SHALL issue after reset.
REQ-034 Handshake inputs SHALL be ignored while rst is high.

Verification
REQ-035 Single legal push: op=0000, a=5, b=7, out_ready=1 -> next cycle out_valid=1, operand_a=5, operand_b=7, alu_control=0000; following cycle out_valid=0.
REQ-036 Backpressure: out_ready=0, push 3 legal ops -> in_ready=0 after the 2nd accept; the 3rd is held; raising out_ready drains the ops in order with no loss.
REQ-037 Illegal drop: push op=0011 then op=1111 -> out_valid stays 0, illegal_cnt=2, err_sticky=1; err_clr pulse -> illegal_cnt=0, err_sticky=0.
REQ-038 Saturation and collision: 300 illegal accepts -> illegal_cnt=255; err_clr together with an illegal accept -> illegal_cnt=1.
REQ-039 Simultaneous push/pop at count==1, streaming at 1/cycle -> count stays 1, throughput 1 op/cycle, order preserved.
REQ-040 Reset while count==2 -> out_valid=0 and in_ready=1 after reset; neither old entry ever appears.
